// File: rtl/rr_arbiter8.sv
// rr_arbiter8: 8-requester round-robin arbiter with bounded grant hold.
// A registered 3-bit grant index drives the shared resource-select decoder.
// gnt is the registered one-hot decoded copy of that index.
// Ports:
//   clk       - system clock, all state updates on rising edge
//   rst       - synchronous active-high reset
//   req[7:0]  - level request vector, bit i = requester i wants the resource
//   gnt[7:0]  - one-hot grant, registered, all-zero when no grant is active
//   gnt_idx   - binary index of the current grantee (decoder select)
//   gnt_valid - high while a grant is active
module rr_arbiter8 #(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid
);

    localparam int unsigned N_REQ    = 8;
    localparam int unsigned IDX_W    = 3;
    localparam int unsigned HOLD_W   = 4;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t              state, state_nxt;
    logic [IDX_W-1:0]    ptr, ptr_nxt;
    logic [IDX_W-1:0]    idx_nxt;
    logic [HOLD_W-1:0]   hold_cnt, hold_nxt;
    logic [N_REQ-1:0]    others_c;
    logic [IDX_W-1:0]    after_c;

    // First set bit of r when searching base, base+1, ... with 3-bit wrap.
    // Scanning from the far end means the nearest hit overwrites the rest.
    function automatic logic [IDX_W-1:0] first_from(input logic [N_REQ-1:0] r,
                                                    input logic [IDX_W-1:0] base);
        logic [IDX_W-1:0] res;
        logic [IDX_W-1:0] pos;
        res = base;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            pos = IDX_W'(base + IDX_W'(i));
            if (r[pos]) res = pos;
        end
        return res;
    endfunction

    // Competing requesters and the position just past the current grantee.
    assign others_c = req & ~(N_REQ'(1) << gnt_idx);
    assign after_c  = IDX_W'(gnt_idx + IDX_W'(1));

    // Next-state, pointer, hold counter and grant index.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        idx_nxt   = gnt_idx;
        hold_nxt  = hold_cnt;
        unique case (state)
            IDLE: begin
                if (req != '0) begin
                    state_nxt = GRANT;
                    idx_nxt   = first_from(req, ptr);
                    hold_nxt  = '0;
                end
            end
            GRANT: begin
                // Release and timeout both rotate priority past the grantee.
                if (!req[gnt_idx] || (hold_cnt == HOLD_LAST && others_c != '0)) begin
                    ptr_nxt = after_c;
                    if (others_c != '0) begin
                        idx_nxt  = first_from(others_c, after_c);
                        hold_nxt = '0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (hold_cnt != HOLD_LAST) begin
                    hold_nxt = HOLD_W'(hold_cnt + HOLD_W'(1));
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and registered outputs; gnt is decoded from the next index.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            hold_cnt  <= '0;
            gnt_idx   <= '0;
            gnt       <= '0;
            gnt_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            hold_cnt  <= hold_nxt;
            gnt_idx   <= idx_nxt;
            gnt       <= (state_nxt == GRANT) ? (N_REQ'(1) << idx_nxt) : '0;
            gnt_valid <= (state_nxt == GRANT);
        end
    end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Bench for rr_arbiter8: directed vector table, hand-written multi-cycle
// sequences and randomized traffic against a behavioural reference model.
module tb_rr_arbiter8;

    localparam int MH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit m_valid;
    int m_idx;
    int m_ptr;
    int m_hold;

    rr_arbiter8 #(.MAX_HOLD(MH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       rst;
        bit [7:0] req;
        bit [7:0] e_gnt;
        int       e_idx;
        bit       e_valid;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // First requester in round-robin order starting from position base.
    function automatic int pick(input bit [7:0] r, input int base);
        for (int k = 0; k < 8; k++)
            if (r[(base + k) % 8]) return (base + k) % 8;
        return -1;
    endfunction

    task automatic model_step(input bit r, input bit [7:0] q);
        bit [7:0] others;
        if (r) begin
            m_valid = 0; m_idx = 0; m_ptr = 0; m_hold = 0;
        end else if (!m_valid) begin
            if (q != 0) begin
                m_idx = pick(q, m_ptr); m_valid = 1; m_hold = 0;
            end
        end else begin
            others = q;
            others[m_idx] = 1'b0;
            if (!q[m_idx] || (m_hold == MH - 1 && others != 0)) begin
                m_ptr = (m_idx + 1) % 8;
                if (others != 0) begin
                    m_idx = pick(others, m_ptr); m_hold = 0;
                end else begin
                    m_valid = 0;
                end
            end else if (m_hold < MH - 1) begin
                m_hold++;
            end
        end
    endtask

    // Apply inputs for one cycle; DUT outputs are sampled 1 time unit after the edge.
    task automatic step(input bit r, input bit [7:0] q);
        rst = r;
        req = q;
        @(posedge clk);
        model_step(r, q);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".valid"}, int'(gnt_valid), int'(m_valid));
        check({tag, ".idx"}, int'(gnt_idx), m_idx);
        check({tag, ".gnt"}, int'(gnt), m_valid ? (1 << m_idx) : 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        step(1'b1, 8'h00);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        req = 8'h00;

        // rst, req, expected gnt, idx, valid
        vecs[0]  = '{1, 8'hFF, 8'h00, 0, 0};
        vecs[1]  = '{1, 8'hFF, 8'h00, 0, 0};
        vecs[2]  = '{0, 8'h04, 8'h04, 2, 1};
        vecs[3]  = '{0, 8'h00, 8'h00, 2, 0};
        vecs[4]  = '{0, 8'h08, 8'h08, 3, 1};
        vecs[5]  = '{0, 8'h4A, 8'h08, 3, 1};
        vecs[6]  = '{0, 8'h42, 8'h40, 6, 1};
        vecs[7]  = '{0, 8'h00, 8'h00, 6, 0};
        vecs[8]  = '{0, 8'h81, 8'h80, 7, 1};
        vecs[9]  = '{0, 8'h01, 8'h01, 0, 1};
        vecs[10] = '{0, 8'h00, 8'h00, 0, 0};

        @(negedge clk);
        for (int i = 0; i < 11; i++) begin
            step(vecs[i].rst, vecs[i].req);
            check($sformatf("vec%0d.gnt", i), int'(gnt), int'(vecs[i].e_gnt));
            check($sformatf("vec%0d.idx", i), int'(gnt_idx), vecs[i].e_idx);
            check($sformatf("vec%0d.valid", i), int'(gnt_valid), int'(vecs[i].e_valid));
            @(negedge clk);
        end

        // All requesting: each index owns MH cycles, in order, wrapping to 0.
        do_reset();
        for (int k = 0; k < 8 * MH + MH; k++) begin
            step(1'b0, 8'hFF);
            check($sformatf("ff%0d.idx", k), int'(gnt_idx), (k / MH) % 8);
            check($sformatf("ff%0d.gnt", k), int'(gnt), 1 << ((k / MH) % 8));
            @(negedge clk);
        end

        // Grantee 5 times out to idx 0 with no dead cycle.
        do_reset();
        step(1'b0, 8'h20);
        check("to.first", int'(gnt_idx), 5);
        @(negedge clk);
        for (int k = 1; k <= MH; k++) begin
            step(1'b0, 8'h21);
            check($sformatf("to%0d.gnt", k), int'(gnt), (k < MH) ? 8'h20 : 8'h01);
            check($sformatf("to%0d.valid", k), int'(gnt_valid), 1);
            @(negedge clk);
        end

        // Lone requester keeps its grant well past MH cycles.
        do_reset();
        for (int k = 0; k < 3 * MH; k++) begin
            step(1'b0, 8'h20);
            check($sformatf("lone%0d.gnt", k), int'(gnt), 8'h20);
            @(negedge clk);
        end

        // Reset pulse mid-grant of idx 4, then round-robin restarts at 0.
        do_reset();
        for (int k = 0; k < 4 * MH + 1; k++) begin
            step(1'b0, 8'hFF);
            @(negedge clk);
        end
        check("rp.pre_idx", int'(gnt_idx), 4);
        step(1'b1, 8'hFF);
        check("rp.rst_gnt", int'(gnt), 0);
        check("rp.rst_valid", int'(gnt_valid), 0);
        check("rp.rst_idx", int'(gnt_idx), 0);
        @(negedge clk);
        step(1'b0, 8'hFF);
        check("rp.regrant", int'(gnt), 8'h01);
        @(negedge clk);

        // Randomized traffic against the reference model.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            bit       r;
            bit [7:0] q;
            r = ($urandom_range(0, 99) == 0);
            case ($urandom_range(0, 3))
                0: q = 8'($urandom) & 8'($urandom);
                1: q = 8'($urandom);
                2: q = 8'h01 << $urandom_range(0, 7);
                default: q = (gnt_valid && $urandom_range(0, 1) == 1) ?
                             (8'($urandom) | gnt) : 8'($urandom);
            endcase
            step(r, q);
            check_model($sformatf("rnd%0d", k));
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
